// File: rtl/mac8_job_sched.sv
// mac8_job_sched
//   Round-robin scheduler that lets two requesters share one external
//   8-lane adder tree (registered inputs and output, 2-cycle latency).
//   A job is a stream of 8-element chunks ended by a last flag. Each chunk
//   is sent to the tree, and the per-chunk sums are accumulated into a wide
//   signed accumulator. One tagged result is returned per job.
//
// Ports
//   clk, reset      clock; synchronous active-high reset (also resets the tree)
//   in_valid[1:0]   per-requester chunk valid
//   in_last[1:0]    per-requester last-chunk-of-job flag
//   in_vec0/1       8 x DATA_WIDTH signed chunk of requester 0 / 1
//   in_ready[1:0]   per-requester chunk accept (one-hot or zero)
//   tree_vec        chunk to the tree; zero unless a chunk is accepted
//   tree_result     tree sum, DATA_WIDTH+3 signed
//   out_valid       job result valid, out_ready consumer ready
//   out_sum         job sum (ACC_WIDTH, wraps)
//   out_id          requester that owned the job
//   out_chunks      chunks accepted in the job (saturating)
module mac8_job_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [1:0]                       in_valid,
    input  logic [1:0]                       in_last,
    input  logic signed [8*DATA_WIDTH-1:0]   in_vec0,
    input  logic signed [8*DATA_WIDTH-1:0]   in_vec1,
    output logic [1:0]                       in_ready,
    output logic signed [8*DATA_WIDTH-1:0]   tree_vec,
    input  logic signed [DATA_WIDTH+2:0]     tree_result,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [ACC_WIDTH-1:0]      out_sum,
    output logic                             out_id,
    output logic [CNT_WIDTH-1:0]             out_chunks
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic                        r_grant;
    logic                        r_rr_ptr;
    logic                        r_pv1;
    logic                        r_pv2;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic [CNT_WIDTH-1:0]        r_cnt;

    logic                        w_accept;
    logic                        w_start;
    logic                        w_grant_next;
    logic                        w_res_hs;
    logic signed [ACC_WIDTH-1:0] w_tree_ext;

    assign w_tree_ext = ACC_WIDTH'(tree_result);

    assign out_sum    = r_acc;
    assign out_id     = r_grant;
    assign out_chunks = r_cnt;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = '0;
        tree_vec     = '0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        w_start      = 1'b0;
        w_res_hs     = 1'b0;
        w_grant_next = r_grant;
        case (r_state)
            IDLE: begin
                if (|in_valid) begin
                    w_start      = 1'b1;
                    w_grant_next = in_valid[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
                    w_state_next = STREAM;
                end
            end
            STREAM: begin
                in_ready = r_grant ? 2'b10 : 2'b01;
                w_accept = in_valid[r_grant];
                if (w_accept) begin
                    tree_vec = r_grant ? in_vec1 : in_vec0;
                    if (in_last[r_grant]) w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Stage 2 is folded into acc at this same edge, so an empty
                // stage 1 means the pipe is empty by the time DONE is entered.
                if (!r_pv1) w_state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_res_hs     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant  <= 1'b0;
            r_rr_ptr <= 1'b0;
            r_pv1    <= 1'b0;
            r_pv2    <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            // Valid tags track the tree's two register stages.
            r_pv1 <= w_accept;
            r_pv2 <= r_pv1;
            if (w_start) begin
                r_grant <= w_grant_next;
                r_acc   <= '0;
                r_cnt   <= '0;
            end else begin
                if (r_pv2) r_acc <= r_acc + w_tree_ext;
                if (w_accept && (r_cnt != '1)) r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
            if (w_res_hs) r_rr_ptr <= ~r_grant;
        end
    end

endmodule

// File: tb/tb_mac8_job_sched.sv
// Bench for mac8_job_sched. Contains a behavioural 2-cycle adder tree and a
// scoreboard of expected job results that is popped on each result handshake.
module tb_mac8_job_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
    logic [63:0] vec0 = '0, vec1 = '0;
    logic [1:0]  in_valid, in_last, in_ready;
    logic signed [63:0] tree_vec;
    logic signed [10:0] tree_result;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic signed [19:0] out_sum;
    logic        out_id;
    logic [7:0]  out_chunks;

    assign in_valid = {v1, v0};
    assign in_last  = {l1, l0};

    mac8_job_sched #(.DATA_WIDTH(8), .ACC_WIDTH(20), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
        .in_vec0(vec0), .in_vec1(vec1), .in_ready(in_ready), .tree_vec(tree_vec),
        .tree_result(tree_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_id(out_id), .out_chunks(out_chunks)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic signed [10:0] lane_sum(input logic [63:0] v);
        logic signed [10:0] s;
        logic signed [7:0]  b;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            b = v[i*8 +: 8];
            s += 11'(b);
        end
        return s;
    endfunction

    function automatic logic [63:0] fill(input logic [7:0] b);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = b;
        return r;
    endfunction

    // Behavioural adder tree: registered inputs, registered output.
    logic [63:0] tr_in;
    always @(posedge clk) begin
        if (reset) begin
            tr_in       <= '0;
            tree_result <= '0;
        end else begin
            tr_in       <= tree_vec;
            tree_result <= lane_sum(tr_in);
        end
    end

    typedef struct {
        logic signed [19:0] sum;
        logic               id;
        logic [7:0]         chunks;
    } exp_t;
    exp_t sb[$];

    int n_pass = 0, n_total = 0;
    int rise_cyc = 0;
    logic prev_ov = 1'b0;
    logic chk_no_r1 = 1'b0;

    // Result scoreboard.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (out_valid && !prev_ov) rise_cyc = cyc;
        prev_ov = out_valid;
        if (out_valid && out_ready) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_result sum=%0d id=%0d chunks=%0d", out_sum, out_id, out_chunks);
            end else begin
                e = sb.pop_front();
                if (out_sum !== e.sum || out_id !== e.id || out_chunks !== e.chunks)
                    $display("FAIL result got sum=%0d id=%0d chunks=%0d want sum=%0d id=%0d chunks=%0d",
                             out_sum, out_id, out_chunks, e.sum, e.id, e.chunks);
                else n_pass++;
            end
        end
    end

    // Per-cycle tree_vec / in_ready monitor.
    initial forever begin
        logic [63:0] exp_tv;
        @(negedge clk);
        exp_tv = '0;
        if (v0 && in_ready[0]) exp_tv = vec0;
        if (v1 && in_ready[1]) exp_tv = vec1;
        n_total++;
        if (tree_vec !== exp_tv || in_ready === 2'b11)
            $display("FAIL tree_vec got %h want %h in_ready=%b", tree_vec, exp_tv, in_ready);
        else n_pass++;
        if (chk_no_r1) begin
            n_total++;
            if (in_ready[1] !== 1'b0) $display("FAIL in_ready1_idle got %b want 0", in_ready[1]);
            else n_pass++;
        end
    end

    task automatic set_req(input int req, input logic v, input logic [63:0] d, input logic l);
        if (req == 0) begin v0 = v; vec0 = d; l0 = l; end
        else          begin v1 = v; vec1 = d; l1 = l; end
    endtask

    // Sends chunks of job with n chunks; stops after 'stop' chunks (abort).
    task automatic send_job(input int req, input int n, input logic [63:0] d, input int gap,
                            input int stop, output int acc_cyc);
        int sent, waited;
        logic acc;
        sent = 0;
        acc_cyc = -1;
        while (sent < n && sent < stop) begin
            set_req(req, 1'b1, d, sent == n - 1);
            acc = 1'b0;
            waited = 0;
            while (!acc) begin
                @(negedge clk);
                if (in_ready[req]) acc = 1'b1;
                @(posedge clk); #1;
                if (!acc) begin
                    waited++;
                    if (waited > 300) begin
                        n_total++;
                        $display("FAIL accept_timeout req=%0d got no in_ready want accept", req);
                        set_req(req, 1'b0, '0, 1'b0);
                        return;
                    end
                end
            end
            acc_cyc = cyc;
            sent++;
            set_req(req, 1'b0, '0, 1'b0);
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drain_sb();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 500) begin @(posedge clk); #1; k++; end
        n_total++;
        if (sb.size() != 0) $display("FAIL drain_timeout got %0d pending want 0", sb.size());
        else n_pass++;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_total++;
        if (in_ready !== 2'b00 || tree_vec !== '0 || out_valid !== 1'b0 ||
            out_sum !== '0 || out_id !== 1'b0 || out_chunks !== '0)
            $display("FAIL %s got rdy=%b tv=%h ov=%b sum=%0d id=%b ch=%0d want all zero",
                     tag, in_ready, tree_vec, out_valid, out_sum, out_id, out_chunks);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_single_chunk();
        int a;
        chk_no_r1 = 1'b1;
        sb.push_back('{sum: 20'sd8, id: 1'b0, chunks: 8'd1});
        send_job(0, 1, fill(8'd1), 0, 1, a);
        drain_sb();
        chk_no_r1 = 1'b0;
        n_total++;
        if (rise_cyc - a != 2) $display("FAIL latency got %0d want 2 (edges after accept)", rise_cyc - a);
        else n_pass++;
    endtask

    task automatic test_bubbles();
        int a;
        sb.push_back('{sum: -20'sd3072, id: 1'b1, chunks: 8'd3});
        send_job(1, 3, fill(8'h80), 3, 3, a);
        drain_sb();
    endtask

    task automatic test_round_robin();
        int a0, a1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.push_back('{sum: 20'sd80, id: 1'b0, chunks: 8'd2});
        sb.push_back('{sum: 20'sd80, id: 1'b1, chunks: 8'd2});
        fork
            send_job(0, 2, fill(8'd5), 0, 2, a0);
            send_job(1, 2, fill(8'd5), 0, 2, a1);
        join
        drain_sb();
        sb.push_back('{sum: 20'sd48, id: 1'b0, chunks: 8'd1});
        sb.push_back('{sum: 20'sd56, id: 1'b1, chunks: 8'd1});
        fork
            send_job(0, 1, fill(8'd6), 0, 1, a0);
            send_job(1, 1, fill(8'd7), 0, 1, a1);
        join
        drain_sb();
    endtask

    task automatic test_hold_ready();
        int a0, a1, hs_edge, k;
        out_ready = 1'b0;
        hs_edge = 0;
        sb.push_back('{sum: 20'sd24, id: 1'b0, chunks: 8'd1});
        sb.push_back('{sum: 20'sd32, id: 1'b1, chunks: 8'd1});
        fork
            send_job(0, 1, fill(8'd3), 0, 1, a0);
            send_job(1, 1, fill(8'd4), 0, 1, a1);
            begin
                k = 0;
                do begin @(negedge clk); k++; end while (!out_valid && k < 200);
                for (int i = 0; i < 5; i++) begin
                    n_total++;
                    if (out_valid !== 1'b1 || out_sum !== 20'sd24 || out_id !== 1'b0 ||
                        out_chunks !== 8'd1 || in_ready !== 2'b00)
                        $display("FAIL hold_stable got ov=%b sum=%0d id=%b ch=%0d rdy=%b want 1/24/0/1/00",
                                 out_valid, out_sum, out_id, out_chunks, in_ready);
                    else n_pass++;
                    @(posedge clk); #1;
                    if (i < 4) @(negedge clk);
                end
                out_ready = 1'b1;
                hs_edge = cyc + 1;
            end
        join
        n_total++;
        if (a1 < hs_edge + 2) $display("FAIL pending_grant got accept edge %0d want >= %0d", a1, hs_edge + 2);
        else n_pass++;
        drain_sb();
    endtask

    task automatic test_mixed();
        int a;
        int lanes[8] = '{127, -128, 1, -1, 100, -100, 0, 127};
        logic [63:0] d;
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            d[i*8 +: 8] = 8'(lanes[i]);
            s += lanes[i];
        end
        // Lanes sum to 126, so two chunks give 252.
        sb.push_back('{sum: 20'(2 * s), id: 1'b0, chunks: 8'd2});
        send_job(0, 2, d, 2, 2, a);
        drain_sb();
    endtask

    task automatic test_reset_midjob();
        int a;
        send_job(1, 4, fill(8'd9), 0, 2, a);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midjob_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_total++;
            if (out_valid !== 1'b0) $display("FAIL aborted_result got ov=%b want 0", out_valid);
            else n_pass++;
        end
        @(posedge clk); #1;
        sb.push_back('{sum: 20'sd16, id: 1'b0, chunks: 8'd1});
        send_job(0, 1, fill(8'd2), 0, 1, a);
        drain_sb();
    endtask

    initial begin
        test_reset();
        test_single_chunk();
        test_bubbles();
        test_round_robin();
        test_hold_ready();
        test_mixed();
        test_reset_midjob();
        repeat (3) @(posedge clk);
        n_total++;
        if (sb.size() != 0) $display("FAIL leftover got %0d want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
